// File: rtl/slot_cfg_pkg.sv
// Shared types and constants for the slot-configuration scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package slot_cfg_pkg;

  localparam int SLOT_W = 3;  // eight virtual slots
  localparam int CARD_W = 8;  // card-ID width

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR,
    HOLDOFF,
    RECONFIG,
    BUSY
  } slot_cfg_state_t;

endpackage

// File: rtl/slot_cfg_sched_if.sv
// Requester and config-port bundle of the slot-configuration scheduler.
// Latency: n/a (wiring only).
// Backpressure: req is held by a requester until its ack pulse.
// Ports: req/req_wr/req_slot/req_card/cfg_card_o (+wp_mask when
// SLOTCFG_WRITE_PROTECT_EN) flow into the scheduler; ack/ack_err/rd_card,
// cfg_slot/cfg_wr/cfg_card_i/cfg_reconfig and busy flow out of it.
interface slot_cfg_sched_if #(
  parameter int NUM_REQ = 3
);
  import slot_cfg_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*SLOT_W-1:0] req_slot;
  logic [NUM_REQ*CARD_W-1:0] req_card;
  logic [NUM_REQ-1:0]        ack;
  logic                      ack_err;
  logic [CARD_W-1:0]         rd_card;
  logic [SLOT_W-1:0]         cfg_slot;
  logic                      cfg_wr;
  logic [CARD_W-1:0]         cfg_card_i;
  logic [CARD_W-1:0]         cfg_card_o;
  logic                      cfg_reconfig;
  logic                      busy;
`ifdef SLOTCFG_WRITE_PROTECT_EN
  logic [7:0]                wp_mask;
`endif

  // Requesters plus the slot controller's config port.
  modport master (
`ifdef SLOTCFG_WRITE_PROTECT_EN
    output wp_mask,
`endif
    output req, req_wr, req_slot, req_card, cfg_card_o,
    input  ack, ack_err, rd_card, cfg_slot, cfg_wr, cfg_card_i, cfg_reconfig, busy
  );

  // The scheduler itself.
  modport slave (
`ifdef SLOTCFG_WRITE_PROTECT_EN
    input  wp_mask,
`endif
    input  req, req_wr, req_slot, req_card, cfg_card_o,
    output ack, ack_err, rd_card, cfg_slot, cfg_wr, cfg_card_i, cfg_reconfig, busy
  );

endinterface

// File: rtl/slot_cfg_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the search pointer.
// Latency: combinational grant; pointer advances on the clock when upd_i is high.
// Backpressure: none; losers simply keep requesting.
// Ports: req_i, upd_i in; gnt_oh_o, gnt_idx_o, gnt_vld_o out.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic                 upd_i,
  output logic [N-1:0]         gnt_oh_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_vld_o
);
  localparam int IDX_W = $clog2(N);

  // Pointer holds the first index to search, i.e. one past the last winner.
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx;
  logic             found;
  logic [IDX_W:0]   j;  // one spare bit so ptr+k can wrap cleanly

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (j >= (IDX_W+1)'(N)) j = j - (IDX_W+1)'(N);
      if (!found && req_i[j[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = j[IDX_W-1:0];
      end
    end
  end

  assign gnt_vld_o = found;
  assign gnt_idx_o = idx;
  assign gnt_oh_o  = found ? (N'(1) << idx) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i && found) ptr_d = (idx == IDX_W'(N-1)) ? '0 : idx + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/slot_cfg_sched.sv
// Shares the slotmaker config port between NUM_REQ requesters; coalesces writes into one reconfig.
// Latency: read ack grant+2, write ack grant+1; reconfig HOLDOFF_CYCLES idle cycles after last write.
// Backpressure: requests wait (held) while an access, HOLDOFF arbitration or BUSY blocks them.
// Ports: clk_logic, system_reset_n; bus (slave modport) carries requester and config-port signals.
// Optional macro SLOTCFG_WRITE_PROTECT_EN adds bus.wp_mask and write rejection via ack_err.
module slot_cfg_sched #(
  parameter int NUM_REQ        = 3,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int BUSY_CYCLES    = 20
) (
  input  logic            clk_logic,
  input  logic            system_reset_n,
  slot_cfg_sched_if.slave bus
);
  import slot_cfg_pkg::*;

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (HOLDOFF_CYCLES > BUSY_CYCLES) ? HOLDOFF_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  slot_cfg_state_t   state_q, state_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CARD_W-1:0] card_q, card_d;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic              ack_err_q, ack_err_d;
  logic [CARD_W-1:0] rd_card_q, rd_card_d;

  logic [NUM_REQ-1:0] arb_req, arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld, arb_upd;
  logic               wp_hit;
  logic [SLOT_W-1:0]  cfg_slot_c;
  logic [CARD_W-1:0]  cfg_card_c;
  logic               cfg_wr_c, cfg_reconfig_c;

  // A requester that sees its ack drops req one cycle later; masking it for
  // that cycle keeps a registered requester from being granted twice.
  assign arb_req = bus.req & ~ack_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk_logic),
    .rst_n     (system_reset_n),
    .req_i     (arb_req),
    .upd_i     (arb_upd),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

`ifdef SLOTCFG_WRITE_PROTECT_EN
  assign wp_hit = bus.wp_mask[slot_q];
`else
  assign wp_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    gnt_idx_d      = gnt_idx_q;
    slot_d         = slot_q;
    card_d         = card_q;
    pending_d      = pending_q;
    cnt_d          = cnt_q;
    ack_d          = '0;
    ack_err_d      = 1'b0;
    rd_card_d      = rd_card_q;
    arb_upd        = 1'b0;
    cfg_slot_c     = '0;
    cfg_card_c     = '0;
    cfg_wr_c       = 1'b0;
    cfg_reconfig_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          arb_upd = 1'b1;
          state_d = (|(arb_oh & bus.req_wr)) ? WR : RD1;
        end
      end
      RD1: begin
        cfg_slot_c = slot_q;
        state_d    = RD2;
      end
      RD2: begin
        // slotmaker registers card_o, so it is valid one cycle after cfg_slot.
        rd_card_d = bus.cfg_card_o;
        ack_d     = NUM_REQ'(1) << gnt_idx_q;
        state_d   = pending_q ? HOLDOFF : IDLE;
      end
      WR: begin
        ack_d = NUM_REQ'(1) << gnt_idx_q;
        if (wp_hit) begin
          ack_err_d = 1'b1;
          state_d   = pending_q ? HOLDOFF : IDLE;
        end else begin
          cfg_slot_c = slot_q;
          cfg_card_c = card_q;
          cfg_wr_c   = 1'b1;
          pending_d  = 1'b1;
          cnt_d      = CNT_W'(HOLDOFF_CYCLES - 1);
          state_d    = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        // A request arriving together with expiry wins; reconfig waits.
        if (arb_vld) begin
          arb_upd = 1'b1;
          state_d = (|(arb_oh & bus.req_wr)) ? WR : RD1;
        end else if (cnt_q == '0) begin
          state_d = RECONFIG;
        end
      end
      RECONFIG: begin
        // Single-cycle pulse: slotmaker edge-detects and would stall on a level.
        cfg_reconfig_c = 1'b1;
        pending_d      = 1'b0;
        cnt_d          = CNT_W'(BUSY_CYCLES - 1);
        state_d        = BUSY;
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (arb_upd) begin
      gnt_idx_d = arb_idx;
      slot_d    = bus.req_slot[arb_idx*SLOT_W +: SLOT_W];
      card_d    = bus.req_card[arb_idx*CARD_W +: CARD_W];
    end
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      slot_q    <= '0;
      card_q    <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      ack_q     <= '0;
      ack_err_q <= 1'b0;
      rd_card_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      slot_q    <= slot_d;
      card_q    <= card_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      ack_err_q <= ack_err_d;
      rd_card_q <= rd_card_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.ack_err      = ack_err_q;
  assign bus.rd_card      = rd_card_q;
  assign bus.cfg_slot     = cfg_slot_c;
  assign bus.cfg_wr       = cfg_wr_c;
  assign bus.cfg_card_i   = cfg_card_c;
  assign bus.cfg_reconfig = cfg_reconfig_c;
  assign bus.busy         = (state_q == HOLDOFF) || (state_q == RECONFIG) || (state_q == BUSY);

endmodule

// File: tb/tb_slot_cfg_sched.sv
// Directed bench for slot_cfg_sched with a registered card-ID table model.
// Latency: n/a.
// Backpressure: n/a.
module tb_slot_cfg_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   n_wr = 0;
  int   n_reconfig = 0;
  logic [7:0] mem [8];

  always #5 clk = ~clk;

  slot_cfg_sched_if #(.NUM_REQ(3)) bus ();

  slot_cfg_sched #(.NUM_REQ(3), .HOLDOFF_CYCLES(16), .BUSY_CYCLES(20)) dut (
    .clk_logic      (clk),
    .system_reset_n (rst_n),
    .bus            (bus)
  );

  // Slot controller config port: registered read, write on cfg_wr.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      mem[4] <= 8'h02;
      bus.cfg_card_o <= 8'h00;
    end else begin
      bus.cfg_card_o <= mem[bus.cfg_slot];
      if (bus.cfg_wr) mem[bus.cfg_slot] <= bus.cfg_card_i;
    end
  end

  always @(negedge clk) begin
    if (bus.cfg_wr) n_wr++;
    if (bus.cfg_reconfig) n_reconfig++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic wr, input logic [2:0] slot, input logic [7:0] card);
    bus.req_wr[r]            = wr;
    bus.req_slot[r*3 +: 3]   = slot;
    bus.req_card[r*8 +: 8]   = card;
    bus.req[r]               = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.req_wr = '0; bus.req_slot = '0; bus.req_card = '0;
`ifdef SLOTCFG_WRITE_PROTECT_EN
    bus.wp_mask = 8'h00;
`endif
    tick(); tick();
    tests++; if (bus.ack !== 3'b000) begin fails++; $display("FAIL reset_ack got %b want 000", bus.ack); end
    tests++; if (bus.ack_err !== 1'b0) begin fails++; $display("FAIL reset_ack_err got %b want 0", bus.ack_err); end
    tests++; if (bus.rd_card !== 8'h00) begin fails++; $display("FAIL reset_rd_card got %h want 00", bus.rd_card); end
    tests++; if (bus.cfg_slot !== 3'd0 || bus.cfg_wr !== 1'b0 || bus.cfg_card_i !== 8'h00)
      begin fails++; $display("FAIL reset_cfg got slot=%0d wr=%b card=%h want 0/0/00", bus.cfg_slot, bus.cfg_wr, bus.cfg_card_i); end
    tests++; if (bus.cfg_reconfig !== 1'b0 || bus.busy !== 1'b0)
      begin fails++; $display("FAIL reset_busy got reconfig=%b busy=%b want 0/0", bus.cfg_reconfig, bus.busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] seq [4];
    int got = 0;
    do_reset();
    for (int r = 0; r < 3; r++) set_req(r, 1'b0, 3'(r), 8'h00);
    for (int c = 0; c < 30 && got < 4; c++) begin
      tick();
      if (bus.ack !== 3'b000) begin seq[got] = bus.ack; got++; end
    end
    tests++; if (got != 4) begin fails++; $display("FAIL rr_count got %0d acks want 4", got); end
    for (int i = 0; i < got; i++) begin
      tests++;
      if (seq[i] !== (3'b001 << (i % 3))) begin
        fails++; $display("FAIL rr_order[%0d] got %b want %b", i, seq[i], 3'b001 << (i % 3));
      end
    end
    bus.req = '0;
    repeat (6) tick();
  endtask

  task automatic test_read();
    int r0 = n_reconfig;
    set_req(1, 1'b0, 3'd4, 8'h00);
    tick();  // RD1
    tests++; if (bus.cfg_slot !== 3'd4 || bus.cfg_wr !== 1'b0)
      begin fails++; $display("FAIL read_rd1 got slot=%0d wr=%b want 4/0", bus.cfg_slot, bus.cfg_wr); end
    tick();  // RD2
    tests++; if (bus.ack !== 3'b000) begin fails++; $display("FAIL read_early_ack got %b want 000", bus.ack); end
    tick();  // grant + 2
    tests++; if (bus.ack !== 3'b010 || bus.rd_card !== 8'h02 || bus.ack_err !== 1'b0)
      begin fails++; $display("FAIL read_ack got ack=%b card=%h err=%b want 010/02/0", bus.ack, bus.rd_card, bus.ack_err); end
    bus.req = '0;
    tick();
    tests++; if (bus.ack !== 3'b000) begin fails++; $display("FAIL read_ack_pulse got %b want 000", bus.ack); end
    tests++; if (n_reconfig != r0) begin fails++; $display("FAIL read_no_reconfig got %0d pulses want 0", n_reconfig - r0); end
  endtask

  task automatic test_write_coalesce();
    int r0 = n_reconfig;
    int w0 = n_wr;
    logic ok;
    set_req(0, 1'b1, 3'd7, 8'h05);
    tick();  // WR
    tests++; if (bus.cfg_wr !== 1'b1 || bus.cfg_slot !== 3'd7 || bus.cfg_card_i !== 8'h05)
      begin fails++; $display("FAIL wr1_cfg got wr=%b slot=%0d card=%h want 1/7/05", bus.cfg_wr, bus.cfg_slot, bus.cfg_card_i); end
    tick();
    tests++; if (bus.ack !== 3'b001 || bus.ack_err !== 1'b0 || bus.busy !== 1'b1)
      begin fails++; $display("FAIL wr1_ack got ack=%b err=%b busy=%b want 001/0/1", bus.ack, bus.ack_err, bus.busy); end
    bus.req = '0;
    tick(); tick(); tick();
    set_req(0, 1'b1, 3'd1, 8'h03);
    tick();  // WR again, served from HOLDOFF
    tests++; if (bus.cfg_wr !== 1'b1 || bus.cfg_slot !== 3'd1 || bus.cfg_card_i !== 8'h03)
      begin fails++; $display("FAIL wr2_cfg got wr=%b slot=%0d card=%h want 1/1/03", bus.cfg_wr, bus.cfg_slot, bus.cfg_card_i); end
    tick();
    tests++; if (bus.ack !== 3'b001) begin fails++; $display("FAIL wr2_ack got %b want 001", bus.ack); end
    bus.req = '0;
    ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (bus.cfg_reconfig !== 1'b0 || bus.busy !== 1'b1) ok = 1'b0;
      tick();
    end
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL holdoff_window got early reconfig or busy low, want 16 quiet busy cycles"); end
    tests++; if (bus.cfg_reconfig !== 1'b1) begin fails++; $display("FAIL reconfig_pulse got %b want 1", bus.cfg_reconfig); end
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.busy !== 1'b1 || bus.cfg_reconfig !== 1'b0) ok = 1'b0;
    end
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL busy_window got busy low or reconfig repeat, want 20 busy cycles"); end
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL busy_end got %b want 0", bus.busy); end
    tests++; if (n_wr - w0 != 2 || n_reconfig - r0 != 1)
      begin fails++; $display("FAIL coalesce_counts got wr=%0d reconfig=%0d want 2/1", n_wr - w0, n_reconfig - r0); end
    tests++; if (mem[7] !== 8'h05 || mem[1] !== 8'h03)
      begin fails++; $display("FAIL coalesce_table got s7=%h s1=%h want 05/03", mem[7], mem[1]); end
  endtask

  task automatic test_busy_block();
    logic ok;
    set_req(0, 1'b1, 3'd2, 8'h07);
    tick(); tick();
    bus.req = '0;
    repeat (16) tick();
    tests++; if (bus.cfg_reconfig !== 1'b1) begin fails++; $display("FAIL bb_reconfig got %b want 1", bus.cfg_reconfig); end
    tick(); tick(); tick();  // BUSY cycle 3
    set_req(2, 1'b0, 3'd2, 8'h00);
    ok = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      if (bus.busy !== 1'b1 || bus.ack !== 3'b000 || bus.cfg_slot !== 3'd0) ok = 1'b0;
    end
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL bb_no_grant got access during BUSY, want none"); end
    tick();  // first IDLE cycle
    tests++; if (bus.busy !== 1'b0 || bus.cfg_slot !== 3'd0)
      begin fails++; $display("FAIL bb_idle got busy=%b slot=%0d want 0/0", bus.busy, bus.cfg_slot); end
    tick();
    tests++; if (bus.cfg_slot !== 3'd2) begin fails++; $display("FAIL bb_rd1 got slot=%0d want 2", bus.cfg_slot); end
    tick(); tick();
    tests++; if (bus.ack !== 3'b100 || bus.rd_card !== 8'h07)
      begin fails++; $display("FAIL bb_ack got ack=%b card=%h want 100/07", bus.ack, bus.rd_card); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_mid_holdoff();
    int r0;
    logic ok;
    set_req(0, 1'b1, 3'd5, 8'h09);
    tick(); tick();
    bus.req = '0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.ack !== 3'b000 || bus.cfg_wr !== 1'b0 || bus.cfg_reconfig !== 1'b0)
      begin fails++; $display("FAIL rst_mid got busy=%b ack=%b wr=%b rc=%b want all 0", bus.busy, bus.ack, bus.cfg_wr, bus.cfg_reconfig); end
    tick(); tick();
    rst_n = 1'b1;
    r0 = n_reconfig;
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.busy !== 1'b0) ok = 1'b0;
    end
    tests++; if (n_reconfig != r0 || ok !== 1'b1)
      begin fails++; $display("FAIL rst_discard got reconfig=%0d busy_ok=%b want 0/1", n_reconfig - r0, ok); end
  endtask

`ifdef SLOTCFG_WRITE_PROTECT_EN
  task automatic test_write_protect();
    int r0 = n_reconfig;
    bus.wp_mask = 8'h80;
    set_req(2, 1'b1, 3'd7, 8'h0A);
    tick();
    tests++; if (bus.cfg_wr !== 1'b0) begin fails++; $display("FAIL wp_no_wr got %b want 0", bus.cfg_wr); end
    tick();
    tests++; if (bus.ack !== 3'b100 || bus.ack_err !== 1'b1 || bus.busy !== 1'b0)
      begin fails++; $display("FAIL wp_ack got ack=%b err=%b busy=%b want 100/1/0", bus.ack, bus.ack_err, bus.busy); end
    bus.req = '0;
    repeat (25) tick();
    tests++; if (n_reconfig != r0) begin fails++; $display("FAIL wp_no_reconfig got %0d want 0", n_reconfig - r0); end
    set_req(2, 1'b1, 3'd6, 8'h0B);
    tick();
    tests++; if (bus.cfg_wr !== 1'b1 || bus.cfg_slot !== 3'd6)
      begin fails++; $display("FAIL wp_ok_wr got wr=%b slot=%0d want 1/6", bus.cfg_wr, bus.cfg_slot); end
    tick();
    tests++; if (bus.ack !== 3'b100 || bus.ack_err !== 1'b0 || bus.busy !== 1'b1)
      begin fails++; $display("FAIL wp_ok_ack got ack=%b err=%b busy=%b want 100/0/1", bus.ack, bus.ack_err, bus.busy); end
    bus.req = '0;
    repeat (40) tick();
    tests++; if (mem[6] !== 8'h0B || mem[7] !== 8'h00 || n_reconfig - r0 != 1)
      begin fails++; $display("FAIL wp_table got s6=%h s7=%h rc=%0d want 0b/00/1", mem[6], mem[7], n_reconfig - r0); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_read();
    test_write_coalesce();
    test_busy_block();
    test_reset_mid_holdoff();
`ifdef SLOTCFG_WRITE_PROTECT_EN
    test_write_protect();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/slot_cfg_sched.md
Name: slot_cfg_sched

Overview:
Scheduler that shares the slot-configuration port of the virtual slot controller between NUM_REQ requesters (e.g. PicoSoC firmware, an Apple II soft-switch register file, an OSD menu).
- Performs single-slot reads and writes of the card-ID table.
- Coalesces bursts of writes into one reconfig pulse.
- Blocks further access while the slot controller re-sweeps its 8 slots.
- Sits between the requesters and the slotmaker_config_if wiring in the top level.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- HOLDOFF_CYCLES, 16, idle cycles after the last write before reconfig is issued.
- BUSY_CYCLES, 20, cycles after the reconfig pulse during which no grant is given (covers the 16-cycle slot sweep plus margin).

Ports:
- clk_logic  in  1  system logic clock.
- system_reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request, held until ack.
- req_wr  in  NUM_REQ  1=write, 0=read.
- req_slot  in  NUM_REQ*3  slot number per requester.
- req_card  in  NUM_REQ*8  card ID to write per requester.
- ack  out  NUM_REQ  one-cycle completion pulse.
- ack_err  out  1  qualifies ack: write rejected.
- rd_card  out  8  read data, valid with ack.
- cfg_slot  out  3  to config interface slot.
- cfg_wr  out  1  to config interface wr.
- cfg_card_i  out  8  to config interface card_i.
- cfg_card_o  in  8  from config interface card_o; registered, valid 1 cycle after cfg_slot.
- cfg_reconfig  out  1  to config interface reconfig.
- busy  out  1  high in HOLDOFF, RECONFIG, BUSY.

Behaviour:
Reset values: all outputs 0, state IDLE, round-robin pointer 0, no write pending.

Arbitration:
- Round-robin, evaluated in IDLE and HOLDOFF only.
- Search starts at the index after the last granted requester.
- Winner is latched as gnt_idx together with its wr/slot/card.

States:
- IDLE: if any req -> grant -> RD1 (read) or WR.
- RD1: cfg_slot = latched slot, cfg_wr = 0 -> RD2.
- RD2: capture cfg_card_o into rd_card; pulse ack[gnt_idx]. Return to HOLDOFF if a write is pending, else IDLE.
- WR:
  - cfg_wr = 1 for exactly one cycle with slot/card.
  - ack[gnt_idx] registered in the same cycle.
  - Set pending; load holdoff counter = HOLDOFF_CYCLES - 1 -> HOLDOFF.
- HOLDOFF:
  - Counter decrements each cycle.
  - A new grant is served normally; a new write reloads the counter (coalescing).
  - At counter 0 with no req -> RECONFIG.
  - If req and counter 0 arrive simultaneously, the request wins; reconfig is deferred.
- RECONFIG: cfg_reconfig = 1 for exactly one cycle (slotmaker edge-detects; a held level would stall it in reconfig). Clear pending; load busy counter = BUSY_CYCLES - 1 -> BUSY.
- BUSY: no grants; requests stay pending. At counter 0 -> IDLE.

Timing:
- Read latency is grant + 2 cycles.
- Write latency is grant + 1 cycle.
- At most one access in flight.
- ack is never asserted for a requester whose req is low at grant time.

Requester and reset rules:
- Requesters must hold req/wr/slot/card stable until ack.
- Dropping req before ack is tolerated: the access completes and the ack is ignored.
- Reset mid-operation: the asynchronous reset returns everything to IDLE; a pending reconfig is discarded, because slotmaker's own reset re-sweeps the table.
- Counters are sized $clog2 of max(HOLDOFF_CYCLES, BUSY_CYCLES); no wrap occurs because reload always precedes decrement-to-zero.

Optional Feature:
Macro: SLOTCFG_WRITE_PROTECT_EN
- With the macro:
  - Adds input wp_mask[7:0].
  - A write to slot s with wp_mask[s]=1 skips cfg_wr and does not set pending.
  - It still pulses ack with ack_err=1 in the WR cycle.
  - Reads are unaffected.
- Without the macro: the wp_mask port is absent and ack_err is constant 0.

Decomposition:
- Shared package slot_cfg_pkg:
  - slot_cfg_state_t enum (IDLE, RD1, RD2, WR, HOLDOFF, RECONFIG, BUSY).
  - SLOT_W=3 and CARD_W=8 constants.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin with last-grant pointer, update enable, one-hot and index grant outputs).

Test Plan:
- Read: requester 1 reads slot 4 preloaded with 0x02 -> cfg_slot=4 in RD1; rd_card=0x02 with ack=3'b010 exactly 2 cycles after grant; cfg_reconfig never asserted.
- Write coalescing: requester 0 writes slot 7=0x05, then slot 1=0x03 after 5 cycles -> two cfg_wr pulses; a single cfg_reconfig pulse 16 idle cycles after the second write; busy stays high for 20 further cycles.
- Round-robin: all three requesters hold read requests from IDLE -> grant order 0,1,2,0; no requester is starved.
- Busy blocking: requester 2 raises req during BUSY -> no grant until BUSY ends, then served first cycle in IDLE.
- Reset mid-HOLDOFF: assert system_reset_n low 3 cycles after a write -> outputs 0 immediately; no cfg_reconfig after release.
- SLOTCFG_WRITE_PROTECT_EN: wp_mask=8'h80, write slot 7 -> ack with ack_err=1, no cfg_wr, no reconfig; write slot 6 -> normal.
